stopwatch_ctrl: RTL and testbench

- Control stage directly upstream of the BCD stopwatch counter chain (mm:ss, 00:00..59:59).
- Turns debounced button levels into start/pause, lap-freeze and clear actions.
- Generates the one-cycle count tick and load strobe that drive the counter.
- Reads back the counter's BCD value and produces the display value, either live or frozen on a lap.

---
 rtl/stopwatch_ctrl_pkg.sv | 34 +++
 rtl/stopwatch_ctrl_if.sv | 30 +++
 rtl/stopwatch_ctrl_btn_edge.sv | 24 ++
 rtl/stopwatch_ctrl.sv | 117 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control slice: BCD digit limits, the full-scale value, FSM state encoding.
// No logic latency; types and constants only.
// No flow control; consumed by the control FSM and its interface.
package stopwatch_ctrl_pkg;

    localparam int unsigned BCD_BIT_WIDTH = 4;

    localparam logic [BCD_BIT_WIDTH-1:0] NINE = 4'd9;
    localparam logic [BCD_BIT_WIDTH-1:0] FIVE = 4'd5;

    // 59:59, the last displayable time; the counter chain must not advance past it.
    localparam logic [15:0] STOPWATCH_FULL = 16'h5959;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_FULL  = 2'd3
    } sw_state_t;

    typedef struct packed {
        logic [BCD_BIT_WIDTH-1:0] min1;
        logic [BCD_BIT_WIDTH-1:0] min0;
        logic [BCD_BIT_WIDTH-1:0] sec1;
        logic [BCD_BIT_WIDTH-1:0] sec0;
    } bcd_time_t;

    // True when every digit of an mm:ss value is inside its own range.
    function automatic logic bcd_time_valid(input bcd_time_t t);
        return (t.sec0 <= NINE) && (t.sec1 <= FIVE) &&
               (t.min0 <= NINE) && (t.min1 <= FIVE);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Bundles the button levels, counter read-back and counter/display controls of the stopwatch controller.
// No latency; wiring only.
// No backpressure; all signals are level or single-cycle strobes.
interface stopwatch_ctrl_if;

    logic        btn_start;
    logic        btn_lap;
    logic        btn_clear;
    logic [15:0] preset_bcd;
    logic [15:0] cur_bcd;
    logic        count_enable;
    logic        load_value_enable;
    logic [15:0] load_value;
    logic [15:0] disp_bcd;
    logic        running;
    logic        lap_active;

    // Driver side: buttons, preset and the counter's current value.
    modport master (
        output btn_start, btn_lap, btn_clear, preset_bcd, cur_bcd,
        input  count_enable, load_value_enable, load_value, disp_bcd, running, lap_active
    );

    // Controller side.
    modport slave (
        input  btn_start, btn_lap, btn_clear, preset_bcd, cur_bcd,
        output count_enable, load_value_enable, load_value, disp_bcd, running, lap_active
    );

endinterface

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Rising-edge detector for one debounced button level.
// Pulse is combinational from the input and the registered previous level (same cycle as the rise).
// No backpressure; one pulse per rising edge, a level held through reset yields no pulse.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    logic r_prev;

    // Previous level resets high so a button held across reset is not seen as a new press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign o_press = i_btn & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/pause, lap freeze and clear; generates count tick and load strobe for the BCD counter.
// Outputs registered, 1 cycle after the press edge; disp_bcd is a mux of registered sources.
// No backpressure; optional STOPWATCH_PRESET_EN makes clear load a validated preset instead of 00:00.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000000,  // must be >= 2
    parameter int unsigned DIV_W    = 27          // 2**DIV_W >= TICK_DIV
) (
    input  logic            clk,
    input  logic            rst,
    stopwatch_ctrl_if.slave bus
);

    localparam logic [DIV_W-1:0] LP_TERM = DIV_W'(TICK_DIV - 1);

    logic        w_start;
    logic        w_lap;
    logic        w_clear;
    logic [15:0] w_clear_val;

    sw_state_t        r_state;
    logic [DIV_W-1:0] r_presc;
    logic             r_lap_active;
    logic [15:0]      r_snap;
    logic             r_count_en;
    logic             r_load_en;
    logic [15:0]      r_load_val;
    logic             r_preset_full;

    btn_edge u_edge_start (.clk(clk), .rst(rst), .i_btn(bus.btn_start), .o_press(w_start));
    btn_edge u_edge_lap   (.clk(clk), .rst(rst), .i_btn(bus.btn_lap),   .o_press(w_lap));
    btn_edge u_edge_clear (.clk(clk), .rst(rst), .i_btn(bus.btn_clear), .o_press(w_clear));

`ifdef STOPWATCH_PRESET_EN
    // An out-of-range preset digit would push the counter into an illegal state, so fall back to 00:00.
    assign w_clear_val = bcd_time_valid(bus.preset_bcd) ? bus.preset_bcd : 16'h0000;
`else
    logic w_preset_unused;
    assign w_preset_unused = ^bus.preset_bcd;
    assign w_clear_val     = 16'h0000;
`endif

    // Control FSM with prescaler, lap snapshot and registered counter strobes; clear outranks start, start outranks lap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_presc       <= '0;
            r_lap_active  <= 1'b0;
            r_snap        <= '0;
            r_count_en    <= 1'b0;
            r_load_en     <= 1'b0;
            r_load_val    <= '0;
            r_preset_full <= 1'b0;
        end else begin
            r_count_en <= 1'b0;
            r_load_en  <= 1'b0;
            if (w_clear) begin
                r_state       <= ST_IDLE;
                r_presc       <= '0;
                r_lap_active  <= 1'b0;
                r_load_en     <= 1'b1;
                r_load_val    <= w_clear_val;
                r_preset_full <= (w_clear_val == STOPWATCH_FULL);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_presc <= '0;
                            // A 59:59 preset has nowhere to count to.
                            r_state <= r_preset_full ? ST_FULL : ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (bus.cur_bcd == STOPWATCH_FULL) begin
                            // Stop before the tick that would wrap the counter.
                            r_state <= ST_FULL;
                        end else if (w_start) begin
                            // Prescaler keeps its phase across the pause.
                            r_state <= ST_PAUSE;
                        end else if (r_presc == LP_TERM) begin
                            r_presc    <= '0;
                            r_count_en <= 1'b1;
                        end else begin
                            r_presc <= r_presc + DIV_W'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (w_start) begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_FULL: begin
                        r_state <= ST_FULL;
                    end
                endcase

                if (w_lap && !w_start && (r_state == ST_RUN || r_state == ST_PAUSE)) begin
                    if (!r_lap_active) begin
                        r_snap       <= bus.cur_bcd;
                        r_lap_active <= 1'b1;
                    end else begin
                        r_lap_active <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.count_enable      = r_count_en;
    assign bus.load_value_enable = r_load_en;
    assign bus.load_value        = r_load_val;
    assign bus.running           = (r_state == ST_RUN);
    assign bus.lap_active        = r_lap_active;
    assign bus.disp_bcd          = r_lap_active ? r_snap : bus.cur_bcd;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4: directed scenarios then random button/counter activity.
// Expected outputs come from a cycle-level reference model of the stopwatch rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_stopwatch_ctrl;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(.TICK_DIV(TD), .DIV_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: mode, cycles spent counting since the last start from IDLE, lap and load state.
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_FULL} mmode_t;
    mmode_t      m_mode;
    int          m_run;
    bit          m_lap;
    logic [15:0] m_snap;
    bit          m_tick;
    bit          m_load;
    logic [15:0] m_loadval;
    bit          m_pfull;
    bit          m_prev_s, m_prev_l, m_prev_c;

    function automatic logic [15:0] clear_value(input logic [15:0] p);
`ifdef STOPWATCH_PRESET_EN
        if (p[3:0] > 4'd9 || p[7:4] > 4'd5 || p[11:8] > 4'd9 || p[15:12] > 4'd5) return 16'h0000;
        return p;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit ps, pl, pc, lap_ok;
        ps = bus.btn_start && !m_prev_s;
        pl = bus.btn_lap   && !m_prev_l;
        pc = bus.btn_clear && !m_prev_c;
        m_prev_s = bus.btn_start;
        m_prev_l = bus.btn_lap;
        m_prev_c = bus.btn_clear;
        m_tick = 0;
        m_load = 0;
        if (rst) begin
            m_prev_s = 1; m_prev_l = 1; m_prev_c = 1;
            m_mode = M_IDLE; m_run = 0; m_lap = 0; m_snap = '0;
            m_loadval = '0; m_pfull = 0;
        end else if (pc) begin
            m_mode = M_IDLE; m_run = 0; m_lap = 0;
            m_load = 1; m_loadval = clear_value(bus.preset_bcd);
            m_pfull = (m_loadval == 16'h5959);
        end else begin
            lap_ok = pl && !ps && (m_mode == M_RUN || m_mode == M_PAUSE);
            if (m_mode == M_IDLE && ps) begin
                m_run  = 0;
                m_mode = m_pfull ? M_FULL : M_RUN;
            end else if (m_mode == M_RUN) begin
                if (bus.cur_bcd == 16'h5959) m_mode = M_FULL;
                else if (ps) m_mode = M_PAUSE;
                else begin
                    m_run++;
                    if (m_run % TD == 0) m_tick = 1;
                end
            end else if (m_mode == M_PAUSE && ps) begin
                m_mode = M_RUN;
            end
            if (lap_ok) begin
                if (!m_lap) begin m_snap = bus.cur_bcd; m_lap = 1; end
                else m_lap = 0;
            end
        end
    endtask

    // One clock: model update, edge, then compare every output against the model.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("running",    16'(bus.running),           16'(m_mode == M_RUN));
        check("count_en",   16'(bus.count_enable),      16'(m_tick));
        check("load_en",    16'(bus.load_value_enable), 16'(m_load));
        check("load_value", bus.load_value,             m_loadval);
        check("lap_active", 16'(bus.lap_active),        16'(m_lap));
        check("disp_bcd",   bus.disp_bcd,               m_lap ? m_snap : bus.cur_bcd);
        check("exclusive",  16'(bus.count_enable & bus.load_value_enable), 16'h0);
    endtask

    initial begin
        int first, nt;
        m_prev_s = 0; m_prev_l = 0; m_prev_c = 0;
        m_mode = M_IDLE; m_run = 0; m_lap = 0; m_snap = '0;
        m_loadval = '0; m_pfull = 0; m_tick = 0; m_load = 0;

        rst = 1;
        bus.btn_start = 1; bus.btn_lap = 0; bus.btn_clear = 0;
        bus.preset_bcd = 16'h0000; bus.cur_bcd = 16'h0000;
        #1;
        cycle();
        cycle();
        check("rst_running", 16'(bus.running), 16'h0);
        check("rst_load_value", bus.load_value, 16'h0000);
        // Start held through reset must not count as a press.
        rst = 0;
        cycle();
        check("held_start", 16'(bus.running), 16'h0);
        bus.btn_start = 0;
        cycle();

        // First tick TD cycles after RUN entry, then every TD cycles.
        bus.btn_start = 1;
        cycle();
        bus.btn_start = 0;
        check("run_entry", 16'(bus.running), 16'h1);
        first = -1; nt = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (bus.count_enable) begin
                if (first < 0) first = k;
                nt++;
            end
        end
        check("first_tick", 16'(first), 16'(TD));
        check("tick_count", 16'(nt), 16'd5);

        // Pause with prescaler at 2, stay paused, resume: tick 2 cycles later.
        cycle(); cycle();
        bus.btn_start = 1;
        cycle();
        bus.btn_start = 0;
        nt = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (bus.count_enable) nt++;
        end
        check("pause_ticks", 16'(nt), 16'd0);
        bus.btn_start = 1;
        cycle();
        bus.btn_start = 0;
        first = -1;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            if (bus.count_enable && first < 0) first = k;
        end
        check("resume_tick", 16'(first), 16'd2);

        // 59:59 reached: FULL, no ticks, start ignored, clear loads 00:00.
        bus.cur_bcd = 16'h5959;
        nt = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (bus.count_enable) nt++;
        end
        check("full_ticks", 16'(nt), 16'd0);
        bus.btn_start = 1;
        cycle();
        bus.btn_start = 0;
        check("full_start", 16'(bus.running), 16'h0);
        bus.btn_clear = 1;
        cycle();
        bus.btn_clear = 0;
        check("full_clear_ld", 16'(bus.load_value_enable), 16'h1);
        check("full_clear_val", bus.load_value, 16'h0000);
        bus.cur_bcd = 16'h0000;
        cycle();
        check("ld_one_cycle", 16'(bus.load_value_enable), 16'h0);

        // Lap freeze and release.
        bus.btn_start = 1;
        cycle();
        bus.btn_start = 0;
        bus.cur_bcd = 16'h0123;
        bus.btn_lap = 1;
        cycle();
        bus.btn_lap = 0;
        bus.cur_bcd = 16'h0130;
        cycle();
        check("lap_frozen", bus.disp_bcd, 16'h0123);
        check("lap_flag", 16'(bus.lap_active), 16'h1);
        bus.btn_lap = 1;
        cycle();
        bus.btn_lap = 0;
        check("lap_release", bus.disp_bcd, 16'h0130);
        bus.btn_lap = 1;
        cycle();
        bus.btn_lap = 0;
        cycle();

        // Clear, start and lap together in RUN: clear wins.
        bus.btn_clear = 1; bus.btn_start = 1; bus.btn_lap = 1;
        cycle();
        check("prio_ld", 16'(bus.load_value_enable), 16'h1);
        check("prio_lap", 16'(bus.lap_active), 16'h0);
        check("prio_run", 16'(bus.running), 16'h0);
        check("prio_tick", 16'(bus.count_enable), 16'h0);
        bus.btn_clear = 0; bus.btn_start = 0; bus.btn_lap = 0;
        cycle();

`ifdef STOPWATCH_PRESET_EN
        bus.preset_bcd = 16'h1030;
        bus.btn_clear = 1;
        cycle();
        bus.btn_clear = 0;
        check("preset_ok", bus.load_value, 16'h1030);
        cycle();
        bus.preset_bcd = 16'h0A00;
        bus.btn_clear = 1;
        cycle();
        bus.btn_clear = 0;
        check("preset_bad", bus.load_value, 16'h0000);
        cycle();
`endif

        // Random activity against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0)  bus.btn_start = ~bus.btn_start;
            if ($urandom_range(0, 6) == 0)  bus.btn_lap   = ~bus.btn_lap;
            if ($urandom_range(0, 25) == 0) bus.btn_clear = ~bus.btn_clear;
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 24) == 0) bus.cur_bcd = 16'h5959;
            else if ($urandom_range(0, 3) == 0) bus.cur_bcd = 16'($urandom);
            case ($urandom_range(0, 3))
                0: bus.preset_bcd = 16'h5959;
                1: bus.preset_bcd = 16'($urandom);
                default: bus.preset_bcd = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                                           4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            endcase
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
